// File: rtl/mem_access_unit.sv
// MEM-stage sequencer: turns loads/stores from EX/MEM into byte-serial accesses
// on the 8-bit RAM port, stalling the pipeline until the access completes.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef EX_LB_OP
`define EX_LB_OP  8'h20
`define EX_LH_OP  8'h21
`define EX_LW_OP  8'h23
`define EX_LBU_OP 8'h24
`define EX_LHU_OP 8'h25
`define EX_SB_OP  8'h28
`define EX_SH_OP  8'h29
`define EX_SW_OP  8'h2b
`endif

module mem_access_unit (
  input  logic              clk,
  input  logic              rst,
  input  logic              me_w_enable,
  input  logic [`RegAddrBus] me_w_addr,
  input  logic [`RegBus]    me_w_data,
  input  logic [`AluOpBus]  me_aluop,
  input  logic [`RegBus]    me_ram_addr,
  input  logic [7:0]        mem_din,
  output logic [31:0]       mem_a,
  output logic [7:0]        mem_dout,
  output logic              mem_wr,
  output logic              stallreq_mem,
  output logic              wb_w_enable,
  output logic [`RegAddrBus] wb_w_addr,
  output logic [`RegBus]    wb_w_data
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t state_q, state_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [1:0]         last_q, last_d;    // n-1
  logic               ld_q, ld_d;
  logic               sgn_q, sgn_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        sdata_q, sdata_d;
  logic [31:0]        buf_q, buf_d;
  logic [`RegAddrBus] rd_q, rd_d;

  logic       dec_mem, dec_ld, dec_sgn;
  logic [1:0] dec_last;
  logic [1:0] samp_idx;
  logic [31:0] ld_val;

  always_comb begin
    dec_mem  = 1'b1;
    dec_ld   = 1'b1;
    dec_sgn  = 1'b0;
    dec_last = 2'd0;
    case (me_aluop)
      `EX_LB_OP:  dec_sgn = 1'b1;
      `EX_LH_OP:  begin dec_sgn = 1'b1; dec_last = 2'd1; end
      `EX_LW_OP:  dec_last = 2'd3;
      `EX_LBU_OP: dec_last = 2'd0;
      `EX_LHU_OP: dec_last = 2'd1;
      `EX_SB_OP:  dec_ld = 1'b0;
      `EX_SH_OP:  begin dec_ld = 1'b0; dec_last = 2'd1; end
      `EX_SW_OP:  begin dec_ld = 1'b0; dec_last = 2'd3; end
      default:    begin dec_mem = 1'b0; dec_ld = 1'b0; end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (dec_mem) state_d = S_ISSUE;
      S_ISSUE: if (cnt_q == last_q) state_d = ld_q ? S_WAIT : S_DONE;
      S_WAIT:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Byte from address cnt-1 arrives during ISSUE; the last byte lands in WAIT.
  assign samp_idx = (state_q == S_WAIT) ? cnt_q : cnt_q - 2'd1;

  always_comb begin
    cnt_d   = cnt_q;
    last_d  = last_q;
    ld_d    = ld_q;
    sgn_d   = sgn_q;
    addr_d  = addr_q;
    sdata_d = sdata_q;
    buf_d   = buf_q;
    rd_d    = rd_q;
    case (state_q)
      S_IDLE: if (dec_mem) begin
        cnt_d   = 2'd0;
        last_d  = dec_last;
        ld_d    = dec_ld;
        sgn_d   = dec_sgn;
        addr_d  = me_ram_addr;
        sdata_d = me_w_data;
        buf_d   = 32'd0;
        rd_d    = me_w_addr;
      end
      S_ISSUE: begin
        if (cnt_q != last_q) cnt_d = cnt_q + 2'd1;
        if (ld_q && cnt_q != 2'd0) buf_d[{samp_idx, 3'b000} +: 8] = mem_din;
      end
      S_WAIT: buf_d[{samp_idx, 3'b000} +: 8] = mem_din;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      last_q  <= 2'd0;
      ld_q    <= 1'b0;
      sgn_q   <= 1'b0;
      addr_q  <= 32'd0;
      sdata_q <= 32'd0;
      buf_q   <= 32'd0;
      rd_q    <= '0;
    end else begin
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ld_q    <= ld_d;
      sgn_q   <= sgn_d;
      addr_q  <= addr_d;
      sdata_q <= sdata_d;
      buf_q   <= buf_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    case (last_q)
      2'd0:    ld_val = {{24{sgn_q & buf_q[7]}}, buf_q[7:0]};
      2'd1:    ld_val = {{16{sgn_q & buf_q[15]}}, buf_q[15:0]};
      default: ld_val = buf_q;
    endcase
  end

  always_comb begin
    mem_a        = 32'd0;
    mem_dout     = 8'd0;
    mem_wr       = 1'b0;
    stallreq_mem = 1'b0;
    wb_w_enable  = 1'b0;
    wb_w_addr    = '0;
    wb_w_data    = 32'd0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (dec_mem) stallreq_mem = 1'b1;
          else begin
            wb_w_enable = me_w_enable;
            wb_w_addr   = me_w_addr;
            wb_w_data   = me_w_data;
          end
        end
        S_ISSUE: begin
          stallreq_mem = 1'b1;
          mem_a        = addr_q + {30'd0, cnt_q};
          if (!ld_q) begin
            mem_wr   = 1'b1;
            mem_dout = sdata_q[{cnt_q, 3'b000} +: 8];
          end
        end
        S_WAIT: stallreq_mem = 1'b1;
        default: if (ld_q) begin
          wb_w_enable = 1'b1;
          wb_w_addr   = rd_q;
          wb_w_data   = ld_val;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 1-cycle-latency byte RAM model.
`ifndef RegAddrBus
`define RegAddrBus 4:0
`endif
`ifndef RegBus
`define RegBus 31:0
`endif
`ifndef AluOpBus
`define AluOpBus 7:0
`endif
`ifndef EX_LB_OP
`define EX_LB_OP  8'h20
`define EX_LH_OP  8'h21
`define EX_LW_OP  8'h23
`define EX_LBU_OP 8'h24
`define EX_LHU_OP 8'h25
`define EX_SB_OP  8'h28
`define EX_SH_OP  8'h29
`define EX_SW_OP  8'h2b
`endif

module tb_mem_access_unit;
  localparam logic [7:0] ADD_OP = 8'h01;

  logic              clk = 1'b0;
  logic              rst;
  logic              me_w_enable;
  logic [`RegAddrBus] me_w_addr;
  logic [`RegBus]    me_w_data;
  logic [`AluOpBus]  me_aluop;
  logic [`RegBus]    me_ram_addr;
  logic [7:0]        mem_din;
  logic [31:0]       mem_a;
  logic [7:0]        mem_dout;
  logic              mem_wr;
  logic              stallreq_mem;
  logic              wb_w_enable;
  logic [`RegAddrBus] wb_w_addr;
  logic [`RegBus]    wb_w_data;

  int total = 0;
  int bad = 0;
  int wr200 = 0;
  logic [7:0] ram [0:1023];

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .me_w_enable(me_w_enable), .me_w_addr(me_w_addr), .me_w_data(me_w_data),
    .me_aluop(me_aluop), .me_ram_addr(me_ram_addr), .mem_din(mem_din),
    .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr),
    .stallreq_mem(stallreq_mem), .wb_w_enable(wb_w_enable),
    .wb_w_addr(wb_w_addr), .wb_w_data(wb_w_data)
  );

  always #5 clk = ~clk;

  // RAM indexed by the low 10 address bits; preloaded while rst is high.
  always @(posedge clk) begin
    if (rst) begin
      ram[10'h020] <= 8'h80;
      ram[10'h3ff] <= 8'h34;
      ram[10'h000] <= 8'h92;
      ram[10'h040] <= 8'h78;
      ram[10'h041] <= 8'h56;
      ram[10'h042] <= 8'h34;
      ram[10'h043] <= 8'h12;
      mem_din <= 8'h00;
    end else begin
      if (mem_wr) ram[mem_a[9:0]] <= mem_dout;
      mem_din <= ram[mem_a[9:0]];
      if (mem_wr && mem_a == 32'h200) wr200 <= wr200 + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [7:0] op, input logic [31:0] addr,
                        input logic [4:0] rd, input logic [31:0] data);
    me_aluop    = op;
    me_ram_addr = addr;
    me_w_addr   = rd;
    me_w_data   = data;
    me_w_enable = 1'b1;
  endtask

  // Issues a load in the current IDLE cycle and checks it through DONE.
  task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input int n, input logic [4:0] rd, input logic [31:0] exp);
    nxt();
    set_op(op, addr, rd, 32'h0);
    #1;
    chk({tag, " c0 stall"}, {31'd0, stallreq_mem}, 32'd1);
    chk({tag, " c0 wr"}, {31'd0, mem_wr}, 32'd0);
    for (int i = 0; i < n; i++) begin
      nxt();
      chk({tag, " addr"}, mem_a, addr + i);
      chk({tag, " rd wr"}, {31'd0, mem_wr}, 32'd0);
    end
    nxt();
    chk({tag, " wait stall"}, {31'd0, stallreq_mem}, 32'd1);
    chk({tag, " wait addr"}, mem_a, 32'd0);
    nxt();
    chk({tag, " done stall"}, {31'd0, stallreq_mem}, 32'd0);
    chk({tag, " wb_en"}, {31'd0, wb_w_enable}, 32'd1);
    chk({tag, " wb_addr"}, {27'd0, wb_w_addr}, {27'd0, rd});
    chk({tag, " wb_data"}, wb_w_data, exp);
  endtask

  initial begin
    logic [7:0] sw_bytes [0:3];
    sw_bytes[0] = 8'h44; sw_bytes[1] = 8'h33; sw_bytes[2] = 8'h22; sw_bytes[3] = 8'h11;

    // Reset held with a store present
    rst = 1'b1;
    set_op(`EX_SW_OP, 32'h100, 5'd3, 32'h11223344);
    nxt(); nxt();
    chk("rst stall", {31'd0, stallreq_mem}, 32'd0);
    chk("rst wr", {31'd0, mem_wr}, 32'd0);
    chk("rst a", mem_a, 32'd0);
    chk("rst dout", {24'd0, mem_dout}, 32'd0);
    chk("rst wb_en", {31'd0, wb_w_enable}, 32'd0);
    chk("rst wb_addr", {27'd0, wb_w_addr}, 32'd0);
    chk("rst wb_data", wb_w_data, 32'd0);

    // SW 0x11223344 @0x100 starts right after release
    nxt();
    rst = 1'b0;
    #1;
    chk("sw c0 stall", {31'd0, stallreq_mem}, 32'd1);
    chk("sw c0 wr", {31'd0, mem_wr}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      nxt();
      chk("sw wr", {31'd0, mem_wr}, 32'd1);
      chk("sw a", mem_a, 32'h100 + k);
      chk("sw dout", {24'd0, mem_dout}, {24'd0, sw_bytes[k]});
      chk("sw stall", {31'd0, stallreq_mem}, 32'd1);
    end
    nxt();
    chk("sw done stall", {31'd0, stallreq_mem}, 32'd0);
    chk("sw done wb_en", {31'd0, wb_w_enable}, 32'd0);
    chk("sw done wr", {31'd0, mem_wr}, 32'd0);

    do_load("lb", `EX_LB_OP, 32'h20, 1, 5'd7, 32'hffffff80);
    do_load("lbu", `EX_LBU_OP, 32'h20, 1, 5'd8, 32'h00000080);
    do_load("lh", `EX_LH_OP, 32'hffffffff, 2, 5'd11, 32'hffff9234);
    do_load("lhu", `EX_LHU_OP, 32'hffffffff, 2, 5'd12, 32'h00009234);

    // Non-memory op passes through combinationally
    nxt();
    set_op(ADD_OP, 32'h0, 5'd5, 32'hdeadbeef);
    #1;
    chk("add wb_en", {31'd0, wb_w_enable}, 32'd1);
    chk("add wb_addr", {27'd0, wb_w_addr}, 32'd5);
    chk("add wb_data", wb_w_data, 32'hdeadbeef);
    chk("add stall", {31'd0, stallreq_mem}, 32'd0);
    chk("add wr", {31'd0, mem_wr}, 32'd0);
    chk("add a", mem_a, 32'd0);
    me_w_data = 32'h0badf00d;
    #1;
    chk("add follow", wb_w_data, 32'h0badf00d);

    // LW @0x40 interrupted by reset in cycle 2, then restarted
    nxt();
    set_op(`EX_LW_OP, 32'h40, 5'd9, 32'h0);
    #1;
    chk("lwr c0 stall", {31'd0, stallreq_mem}, 32'd1);
    nxt();
    chk("lwr c1 a", mem_a, 32'h40);
    nxt();
    rst = 1'b1;
    #1;
    chk("lwr c2 stall", {31'd0, stallreq_mem}, 32'd0);
    chk("lwr c2 a", mem_a, 32'd0);
    nxt();
    chk("lwr c3 stall", {31'd0, stallreq_mem}, 32'd0);
    chk("lwr c3 wr", {31'd0, mem_wr}, 32'd0);
    chk("lwr c3 wb_en", {31'd0, wb_w_enable}, 32'd0);
    nxt();
    rst = 1'b0;
    #1;
    chk("lwr restart stall", {31'd0, stallreq_mem}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("lwr addr", mem_a, 32'h40 + i);
    end
    nxt();
    chk("lwr wait stall", {31'd0, stallreq_mem}, 32'd1);
    nxt();
    chk("lwr wb_en", {31'd0, wb_w_enable}, 32'd1);
    chk("lwr wb_addr", {27'd0, wb_w_addr}, 32'd9);
    chk("lwr wb_data", wb_w_data, 32'h12345678);

    // SB then LW back-to-back
    nxt();
    set_op(`EX_SB_OP, 32'h200, 5'd1, 32'hcafe00ab);
    #1;
    chk("sb c0 stall", {31'd0, stallreq_mem}, 32'd1);
    nxt();
    chk("sb wr", {31'd0, mem_wr}, 32'd1);
    chk("sb a", mem_a, 32'h200);
    chk("sb dout", {24'd0, mem_dout}, 32'h000000ab);
    nxt();
    chk("sb done stall", {31'd0, stallreq_mem}, 32'd0);
    chk("sb done wb_en", {31'd0, wb_w_enable}, 32'd0);
    do_load("b2b lw", `EX_LW_OP, 32'h40, 4, 5'd10, 32'h12345678);
    chk("sb write count", wr200, 32'd1);
    chk("sb ram byte", {24'd0, ram[10'h200]}, 32'h000000ab);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
